// File: rtl/hex_disp_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_disp_ctrl_pkg                                                  |
// | Digit register field layout and segment constants for the hex     |
// | display stage.                                                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package hex_disp_ctrl_pkg;

  localparam int c_VAL_LSB = 0;
  localparam int c_VAL_MSB = 3;
  localparam int c_BLANK_BIT = 4;
  localparam int c_BLINK_BIT = 5;

  localparam logic [6:0] c_SEG_OFF = 7'h7F;
  localparam logic [5:0] c_DIG_RST = 6'b010000;

  typedef struct packed {
    logic       blink;
    logic       blank;
    logic [3:0] val;
  } digit_t;

endpackage : hex_disp_ctrl_pkg
`default_nettype wire

// File: rtl/hex_disp_ctrl_hex2seg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_disp_ctrl_hex2seg                                              |
// | Combinational 4-bit to active-low 7-segment {g,f,e,d,c,b,a}.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hex_disp_ctrl_hex2seg (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // Lowercase b and d so they stay distinct from 8 and 0.
  always_comb begin
    o_seg = 7'h7F;
    case (i_val)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule : hex_disp_ctrl_hex2seg
`default_nettype wire

// File: rtl/hex_disp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_disp_ctrl                                                      |
// | Four digit registers with blank/blink, shared blink timer,        |
// | registered segment outputs and CPU readback mux.                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hex_disp_ctrl
  import hex_disp_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 12500000,
  parameter int CNT_W      = 24
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] data_in,
  input  logic        cs_hex0,
  input  logic        cs_hex1,
  input  logic        cs_hex2,
  input  logic        cs_hex3,
  input  logic        read_hex0,
  input  logic        read_hex1,
  input  logic        read_hex2,
  input  logic        read_hex3,
  output logic [15:0] data_out,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [3:0]       w_cs;
  logic [3:0][5:0]  w_dig;
  logic [3:0][6:0]  w_hex;
  logic             w_unused_data;

  assign w_cs          = {cs_hex3, cs_hex2, cs_hex1, cs_hex0};
  assign w_unused_data = ^data_in[15:6];

  // Free-running and never touched by writes, so all blinking digits flash together.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    digit_t     r_dig;
    logic [6:0] r_hex;
    logic [6:0] w_seg;

    hex_disp_ctrl_hex2seg u_dec (
      .i_val(r_dig.val),
      .o_seg(w_seg)
    );

    always_ff @(posedge cpu_clk or negedge rst) begin
      if (!rst) begin
        r_dig <= digit_t'(c_DIG_RST);
        r_hex <= c_SEG_OFF;
      end else begin
        if (w_cs[gi] && we) begin
          r_dig <= digit_t'(data_in[5:0]);
        end
        r_hex <= (r_dig.blank || (r_dig.blink && r_phase)) ? c_SEG_OFF : w_seg;
      end
    end

    assign w_dig[gi] = r_dig;
    assign w_hex[gi] = r_hex;
  end

  assign HEX0 = w_hex[0];
  assign HEX1 = w_hex[1];
  assign HEX2 = w_hex[2];
  assign HEX3 = w_hex[3];

  // Zero when idle so the result can be ORed onto a shared read bus.
  always_comb begin
    data_out = 16'h0000;
    if (read_hex0) begin
      data_out = {10'b0, w_dig[0]};
    end else if (read_hex1) begin
      data_out = {10'b0, w_dig[1]};
    end else if (read_hex2) begin
      data_out = {10'b0, w_dig[2]};
    end else if (read_hex3) begin
      data_out = {10'b0, w_dig[3]};
    end
  end

endmodule : hex_disp_ctrl
`default_nettype wire
